// File: rtl/rsa_exp_ctrl.sv
// rtl/rsa_exp_ctrl.sv - Montgomery modular exponentiation sequencer (c = m^e mod p)
// Drives one shared Montgomery multiplier through a start/done handshake, scanning e MSB first.
module rsa_exp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start_cmd,
  input  logic             stop_cmd,
  input  logic [WIDTH-1:0] rsa_p,
  input  logic [WIDTH-1:0] rsa_e,
  input  logic [WIDTH-1:0] rsa_m,
  input  logic [WIDTH-1:0] rsa_const,
  output logic [WIDTH-1:0] rsa_c,
  output logic             eoc,
  output logic             busy,
  output logic             mmul_start,
  output logic [WIDTH-1:0] mmul_a,
  output logic [WIDTH-1:0] mmul_b,
  output logic [WIDTH-1:0] mmul_n,
  input  logic             mmul_done,
  input  logic [WIDTH-1:0] mmul_result
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE_M  = 3'd1,
    PRE_X  = 3'd2,
    SQUARE = 3'd3,
    MULT   = 3'd4,
    POST   = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t           r_state;
  logic             r_wait;
  logic [WIDTH-1:0] r_e;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_k;
  logic [WIDTH-1:0] r_mbar;
  logic [WIDTH-1:0] r_x;
  logic [IW-1:0]    r_i;

  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic             w_last_bit;

  // Operand pair for the multiply issued by the current state.
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    case (r_state)
      PRE_M:  begin w_op_a = r_m;    w_op_b = r_k; end
      PRE_X:  begin w_op_a = ONE;    w_op_b = r_k; end
      SQUARE: begin w_op_a = r_x;    w_op_b = r_x; end
      MULT:   begin w_op_a = r_mbar; w_op_b = r_x; end
      POST:   begin w_op_a = r_x;    w_op_b = ONE; end
      default: begin w_op_a = '0;    w_op_b = '0;  end
    endcase
  end

  assign w_last_bit = (r_i == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wait     <= 1'b0;
      r_e        <= '0;
      r_m        <= '0;
      r_k        <= '0;
      r_mbar     <= '0;
      r_x        <= '0;
      r_i        <= '0;
      rsa_c      <= '0;
      eoc        <= 1'b0;
      busy       <= 1'b0;
      mmul_start <= 1'b0;
      mmul_a     <= '0;
      mmul_b     <= '0;
      mmul_n     <= '0;
    end else if (ena) begin
      mmul_start <= 1'b0;
      eoc        <= 1'b0;
      // Abort beats start, done and any other pending action.
      if (stop_cmd && busy) begin
        r_state <= IDLE;
        r_wait  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start_cmd && !stop_cmd) begin
              r_e     <= rsa_e;
              r_m     <= rsa_m;
              r_k     <= rsa_const;
              mmul_n  <= rsa_p;
              busy    <= 1'b1;
              r_i     <= IW'(WIDTH - 1);
              r_wait  <= 1'b0;
              r_state <= PRE_M;
            end
          end
          DONE: begin
            r_state <= IDLE;
          end
          default: begin
            if (!r_wait) begin
              mmul_a     <= w_op_a;
              mmul_b     <= w_op_b;
              mmul_start <= 1'b1;
              r_wait     <= 1'b1;
            end else if (mmul_done) begin
              r_wait <= 1'b0;
              case (r_state)
                PRE_M: begin
                  r_mbar  <= mmul_result;
                  r_state <= PRE_X;
                end
                PRE_X: begin
                  r_x     <= mmul_result;
                  r_state <= SQUARE;
                end
                SQUARE: begin
                  r_x <= mmul_result;
                  if (r_e[r_i]) begin
                    r_state <= MULT;
                  end else if (w_last_bit) begin
                    r_state <= POST;
                  end else begin
                    r_i     <= r_i - IW'(1);
                    r_state <= SQUARE;
                  end
                end
                MULT: begin
                  r_x <= mmul_result;
                  if (w_last_bit) begin
                    r_state <= POST;
                  end else begin
                    r_i     <= r_i - IW'(1);
                    r_state <= SQUARE;
                  end
                end
                POST: begin
                  rsa_c   <= mmul_result;
                  eoc     <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= DONE;
                end
                default: begin
                  r_state <= IDLE;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// tb/tb_rsa_exp_ctrl.sv - self-checking bench for rsa_exp_ctrl
// Multiplier modelled with fixed latency; results checked against plain modular arithmetic.
module tb_rsa_exp_ctrl;

  localparam int W   = 8;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic         start_cmd;
  logic         stop_cmd;
  logic [W-1:0] rsa_p;
  logic [W-1:0] rsa_e;
  logic [W-1:0] rsa_m;
  logic [W-1:0] rsa_const;
  logic [W-1:0] rsa_c;
  logic         eoc;
  logic         busy;
  logic         mmul_start;
  logic [W-1:0] mmul_a;
  logic [W-1:0] mmul_b;
  logic [W-1:0] mmul_n;
  logic         mmul_done;
  logic [W-1:0] mmul_result;

  int errors = 0;
  int checks = 0;
  int n_start = 0;
  int n_eoc = 0;
  int base_cycles = 0;

  logic         m_pend;
  int           m_cnt;
  logic [W-1:0] m_res;

  rsa_exp_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .start_cmd(start_cmd), .stop_cmd(stop_cmd),
    .rsa_p(rsa_p), .rsa_e(rsa_e), .rsa_m(rsa_m), .rsa_const(rsa_const),
    .rsa_c(rsa_c), .eoc(eoc), .busy(busy),
    .mmul_start(mmul_start), .mmul_a(mmul_a), .mmul_b(mmul_b), .mmul_n(mmul_n),
    .mmul_done(mmul_done), .mmul_result(mmul_result)
  );

  always #5 clk = ~clk;

  // MM(a,b): the t in [0,n) with t*R == a*b (mod n), found by search.
  function automatic int mm(input int a, input int b, input int n);
    if (n <= 1) return 0;
    for (int t = 0; t < n; t++)
      if (((t * (1 << W)) % n) == ((a * b) % n)) return t;
    return 0;
  endfunction

  function automatic int modpow(input int m, input int e, input int p);
    int r;
    r = 1 % p;
    for (int j = 0; j < e; j++) r = (r * m) % p;
    return r;
  endfunction

  // Multiplier model sharing the clock enable: freezes (done held) while ena=0.
  always @(posedge clk) begin
    if (rst) begin
      mmul_done   <= 1'b0;
      mmul_result <= '0;
      m_pend      <= 1'b0;
      m_cnt       <= 0;
      m_res       <= '0;
    end else if (ena) begin
      mmul_done <= 1'b0;
      if (mmul_start && !m_pend) begin
        m_pend <= 1'b1;
        m_cnt  <= LAT - 1;
        m_res  <= W'(mm(int'(mmul_a), int'(mmul_b), int'(mmul_n)));
      end else if (m_pend) begin
        if (m_cnt == 1) begin
          mmul_done   <= 1'b1;
          mmul_result <= m_res;
          m_pend      <= 1'b0;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (ena && !rst && mmul_start) n_start <= n_start + 1;
    if (ena && !rst && eoc) n_eoc <= n_eoc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int p, input int e, input int m);
    rsa_p     = W'(p);
    rsa_e     = W'(e);
    rsa_m     = W'(m);
    rsa_const = W'((1 << (2 * W)) % p);
  endtask

  // Pulses start and waits (bounded) for eoc; cyc counts edges from the start edge.
  task automatic run(input int p, input int e, input int m,
                     output int cyc, output bit ok, output bit busy1);
    set_ops(p, e, m);
    start_cmd = 1'b1;
    tick();
    start_cmd = 1'b0;
    busy1 = busy;
    cyc = 1;
    ok = 1'b0;
    for (int j = 0; j < 3000; j++) begin
      if (eoc) begin
        ok = 1'b1;
        break;
      end
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; start_cmd = 1'b0; stop_cmd = 1'b0;
    set_ops(187, 7, 88);
    tick(); tick();
    ena = 1'b1;
    tick();
    checks++;
    if ({rsa_c, eoc, busy, mmul_start} !== '0) begin
      errors++;
      $display("FAIL reset_out rsa_c=%0d eoc=%b busy=%b start=%b required all 0", rsa_c, eoc, busy, mmul_start);
    end
    checks++;
    if ({mmul_a, mmul_b, mmul_n} !== '0) begin
      errors++;
      $display("FAIL reset_mmul a=%0d b=%0d n=%0d required 0", mmul_a, mmul_b, mmul_n);
    end
    rst = 1'b0;
    tick(); tick();
  endtask

  task automatic test_basic();
    int cyc; bit ok; bit b1; int s0; int e0;
    s0 = n_start; e0 = n_eoc;
    run(187, 7, 88, cyc, ok, b1);
    base_cycles = cyc;
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout eoc never seen"); end
    checks++;
    if (b1 !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start busy=%b required 1", b1); end
    checks++;
    if (rsa_c !== W'(11)) begin errors++; $display("FAIL basic_result rsa_c=%0d required 11", rsa_c); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_eoc busy=%b required 0", busy); end
    tick();
    checks++;
    if (eoc !== 1'b0) begin errors++; $display("FAIL basic_eoc_width eoc=%b required 0", eoc); end
    tick(); tick();
    checks++;
    if (n_start - s0 != 14) begin errors++; $display("FAIL basic_mul_count got %0d required 14", n_start - s0); end
    checks++;
    if (n_eoc - e0 != 1) begin errors++; $display("FAIL basic_eoc_count got %0d required 1", n_eoc - e0); end
  endtask

  task automatic test_edge_operands();
    int cyc; bit ok; bit b1; int s0;
    s0 = n_start;
    run(187, 0, 88, cyc, ok, b1);
    tick(); tick();
    checks++;
    if (!ok || rsa_c !== W'(1)) begin errors++; $display("FAIL e0_result rsa_c=%0d ok=%b required 1", rsa_c, ok); end
    checks++;
    if (n_start - s0 != 11) begin errors++; $display("FAIL e0_mul_count got %0d required 11", n_start - s0); end
    run(187, 5, 0, cyc, ok, b1);
    tick(); tick();
    checks++;
    if (!ok || rsa_c !== W'(0)) begin errors++; $display("FAIL m0_result rsa_c=%0d ok=%b required 0", rsa_c, ok); end
  endtask

  task automatic test_stop();
    int cyc; bit ok; bit b1; int s0; int e0; bit hit;
    run(187, 7, 88, cyc, ok, b1);
    tick(); tick();
    set_ops(187, 7, 88);
    s0 = n_start; e0 = n_eoc;
    start_cmd = 1'b1; tick(); start_cmd = 1'b0;
    hit = 1'b0;
    for (int j = 0; j < 200; j++) begin
      if (n_start - s0 == 5) begin hit = 1'b1; break; end
      tick();
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL stop_reach_5th timeout starts=%0d required 5", n_start - s0); end
    stop_cmd = 1'b1; tick(); stop_cmd = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy busy=%b required 0", busy); end
    for (int j = 0; j < 20; j++) tick();
    checks++;
    if (n_eoc != e0 || n_start - s0 != 5) begin
      errors++;
      $display("FAIL stop_quiet eoc=%0d starts=%0d required 0 and 5", n_eoc - e0, n_start - s0);
    end
    checks++;
    if (rsa_c !== W'(11) || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_hold rsa_c=%0d busy=%b required 11 and 0", rsa_c, busy);
    end
    run(187, 7, 88, cyc, ok, b1);
    tick(); tick();
    checks++;
    if (!ok || rsa_c !== W'(11)) begin errors++; $display("FAIL stop_rerun rsa_c=%0d ok=%b required 11", rsa_c, ok); end
  endtask

  task automatic test_ignore();
    int s0; bit ok;
    set_ops(187, 7, 88);
    s0 = n_start;
    start_cmd = 1'b1; tick(); start_cmd = 1'b0;
    for (int j = 0; j < 12; j++) tick();
    rsa_m = W'(5);
    start_cmd = 1'b1; tick(); start_cmd = 1'b0;
    ok = 1'b0;
    for (int j = 0; j < 3000; j++) begin
      if (eoc) begin ok = 1'b1; break; end
      tick();
    end
    tick(); tick();
    checks++;
    if (!ok || rsa_c !== W'(11)) begin errors++; $display("FAIL ignore_result rsa_c=%0d ok=%b required 11", rsa_c, ok); end
    checks++;
    if (n_start - s0 != 14) begin errors++; $display("FAIL ignore_mul_count got %0d required 14", n_start - s0); end
    set_ops(187, 7, 88);
    s0 = n_start;
    start_cmd = 1'b1; stop_cmd = 1'b1; tick(); start_cmd = 1'b0; stop_cmd = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_busy busy=%b required 0", busy); end
    for (int j = 0; j < 8; j++) tick();
    checks++;
    if (n_start != s0) begin errors++; $display("FAIL start_stop_quiet starts=%0d required 0", n_start - s0); end
  endtask

  task automatic test_freeze();
    int cyc; bit ok; bit hit;
    set_ops(187, 7, 88);
    start_cmd = 1'b1; tick(); start_cmd = 1'b0;
    cyc = 1;
    hit = 1'b0;
    for (int j = 0; j < 200; j++) begin
      if (mmul_done && n_start > 0 && busy) begin hit = 1'b1; break; end
      tick(); cyc++;
    end
    for (int j = 0; j < 25 && hit; j++) begin
      if (mmul_done && j > 12) break;
      tick(); cyc++;
    end
    checks++;
    if (!hit || !mmul_done) begin errors++; $display("FAIL freeze_setup done=%b required 1", mmul_done); end
    ena = 1'b0;
    for (int j = 0; j < 10; j++) begin tick(); cyc++; end
    ena = 1'b1;
    ok = 1'b0;
    for (int j = 0; j < 3000; j++) begin
      if (eoc) begin ok = 1'b1; break; end
      tick(); cyc++;
    end
    checks++;
    if (!ok || rsa_c !== W'(11)) begin errors++; $display("FAIL freeze_result rsa_c=%0d ok=%b required 11", rsa_c, ok); end
    checks++;
    if (cyc != base_cycles + 10) begin errors++; $display("FAIL freeze_cycles got %0d required %0d", cyc, base_cycles + 10); end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok; bit b1; int s0;
    set_ops(187, 7, 88);
    start_cmd = 1'b1; tick(); start_cmd = 1'b0;
    for (int j = 0; j < 9; j++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({rsa_c, eoc, busy, mmul_start, mmul_a, mmul_b, mmul_n} !== '0) begin
      errors++;
      $display("FAIL midreset_out rsa_c=%0d busy=%b n=%0d a=%0d b=%0d required all 0", rsa_c, busy, mmul_n, mmul_a, mmul_b);
    end
    tick(); tick();
    s0 = n_start;
    run(33, 3, 7, cyc, ok, b1);
    tick(); tick();
    checks++;
    if (!ok || rsa_c !== W'(13)) begin errors++; $display("FAIL midreset_rerun rsa_c=%0d ok=%b required 13", rsa_c, ok); end
    checks++;
    if (n_start - s0 != 13) begin errors++; $display("FAIL midreset_mul_count got %0d required 13", n_start - s0); end
  endtask

  task automatic test_random();
    int cyc; bit ok; bit b1; int s0; int p; int e; int m; int exp_c; int exp_n;
    for (int r = 0; r < 8; r++) begin
      p = int'($urandom_range(1, 127)) * 2 + 1;
      e = int'($urandom_range(0, 255));
      m = int'($urandom_range(0, 255));
      exp_c = modpow(m % p, e, p);
      exp_n = 3 + W + $countones(e[W-1:0]);
      s0 = n_start;
      run(p, e, m, cyc, ok, b1);
      tick(); tick();
      checks++;
      if (!ok || rsa_c !== W'(exp_c)) begin
        errors++;
        $display("FAIL rand_result p=%0d e=%0d m=%0d rsa_c=%0d ok=%b required %0d", p, e, m, rsa_c, ok, exp_c);
      end
      checks++;
      if (n_start - s0 != exp_n) begin
        errors++;
        $display("FAIL rand_mul_count e=%0d got %0d required %0d", e, n_start - s0, exp_n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edge_operands();
    test_stop();
    test_ignore();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
